ebu_arbiter: RTL and testbench

EBU_ARBITER -- requirements
Module: ebu_arbiter

---
 rtl/ebu_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ebu_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ebu_arbiter.sv
// ebu_arbiter: two-master (LSU/IFU) AHB bus arbiter with round-robin tie break.
// A grant is held until the owner's final data beat. Address and data phases
// are tracked by separate counters, so address beat k+1 overlaps data beat k.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   S_IDLE     | bus idle; requests sampled and arbitrated each edge
//   S_LSU_XFER | LSU owns the bus; address/data beats in progress
//   S_IFU_XFER | IFU owns the bus; address/data beats in progress
module ebu_arbiter #(
    parameter int AHBW     = 64,
    parameter int PA_BITS  = 34,
    parameter int BURST_EN = 1
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    input  logic               IFUReq,
    input  logic               IFUBurst,
    input  logic [PA_BITS-1:0] IFUAddr,
    input  logic               LSUReq,
    input  logic               LSUBurst,
    input  logic               LSUWrite,
    input  logic [PA_BITS-1:0] LSUAddr,
    input  logic               HREADY,
    output logic               IFUGrant,
    output logic               LSUGrant,
    output logic               IFUDone,
    output logic               LSUDone,
    output logic [PA_BITS-1:0] HADDR,
    output logic [1:0]         HTRANS,
    output logic [2:0]         HBURST,
    output logic               HWRITE
);

    localparam logic [PA_BITS-1:0] STEP = PA_BITS'(AHBW / 8);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;
    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR4  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LSU_XFER = 2'd1,
        S_IFU_XFER = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 ifu_skip_q, ifu_skip_d;
    logic [PA_BITS-1:0]   base_q, base_d;
    logic                 burst_q, burst_d;
    logic                 write_q, write_d;
    logic [2:0]           addr_cnt_q, addr_cnt_d;
    logic [2:0]           data_cnt_q, data_cnt_d;

    logic [2:0]           n_beats;
    logic                 in_xfer;
    logic                 addr_pend;
    logic                 addr_acc;
    logic                 data_acc;
    logic                 last_beat;

    // Beat bookkeeping shared by next-state and output logic.
    always_comb begin
        n_beats   = burst_q ? 3'd4 : 3'd1;
        in_xfer   = (state_q != S_IDLE);
        addr_pend = (addr_cnt_q < n_beats);
        addr_acc  = in_xfer && addr_pend && HREADY;
        data_acc  = in_xfer && (addr_cnt_q > data_cnt_q) && HREADY;
        last_beat = data_acc && (data_cnt_q == (n_beats - 3'd1));
    end

    // State and transaction context registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            ifu_skip_q <= 1'b0;
            base_q     <= '0;
            burst_q    <= 1'b0;
            write_q    <= 1'b0;
            addr_cnt_q <= 3'd0;
            data_cnt_q <= 3'd0;
        end else begin
            state_q    <= state_d;
            ifu_skip_q <= ifu_skip_d;
            base_q     <= base_d;
            burst_q    <= burst_d;
            write_q    <= write_d;
            addr_cnt_q <= addr_cnt_d;
            data_cnt_q <= data_cnt_d;
        end
    end

    // Arbitration in idle; beat counting until the final data beat.
    always_comb begin
        state_d    = state_q;
        ifu_skip_d = ifu_skip_q;
        base_d     = base_q;
        burst_d    = burst_q;
        write_d    = write_q;
        addr_cnt_d = addr_cnt_q;
        data_cnt_d = data_cnt_q;
        case (state_q)
            S_IDLE: begin
                addr_cnt_d = 3'd0;
                data_cnt_d = 3'd0;
                // IFUSkip records that the IFU lost the last tie, so it wins the next one.
                if (LSUReq && (!IFUReq || !ifu_skip_q)) begin
                    state_d    = S_LSU_XFER;
                    base_d     = LSUAddr;
                    burst_d    = LSUBurst;
                    write_d    = LSUWrite;
                    ifu_skip_d = IFUReq ? 1'b1 : ifu_skip_q;
                end else if (IFUReq) begin
                    state_d    = S_IFU_XFER;
                    base_d     = IFUAddr;
                    burst_d    = IFUBurst;
                    write_d    = 1'b0;
                    ifu_skip_d = 1'b0;
                end
            end
            default: begin
                if (last_beat) begin
                    state_d    = S_IDLE;
                    addr_cnt_d = 3'd0;
                    data_cnt_d = 3'd0;
                end else begin
                    addr_cnt_d = addr_cnt_q + {2'b00, addr_acc};
                    data_cnt_d = data_cnt_q + {2'b00, data_acc};
                end
            end
        endcase
    end

    // AHB and handshake outputs; everything is zero outside a transfer.
    always_comb begin
        IFUGrant = 1'b0;
        LSUGrant = 1'b0;
        IFUDone  = 1'b0;
        LSUDone  = 1'b0;
        HADDR    = '0;
        HTRANS   = TR_IDLE;
        HBURST   = BU_SINGLE;
        HWRITE   = 1'b0;
        if (in_xfer) begin
            LSUGrant = (state_q == S_LSU_XFER);
            IFUGrant = (state_q == S_IFU_XFER);
            LSUDone  = last_beat && (state_q == S_LSU_XFER);
            IFUDone  = last_beat && (state_q == S_IFU_XFER);
            HADDR    = base_q + (PA_BITS'(addr_cnt_q) * STEP);
            HWRITE   = write_q;
            HBURST   = (burst_q && (BURST_EN != 0)) ? BU_INCR4 : BU_SINGLE;
            if (addr_pend) begin
                HTRANS = ((addr_cnt_q == 3'd0) || (BURST_EN == 0)) ? TR_NONSEQ : TR_SEQ;
            end
        end
    end

endmodule

// File: tb/tb_ebu_arbiter.sv
// Testbench for ebu_arbiter: directed scenarios plus randomized traffic, both
// checked cycle by cycle against a transaction-level model (queue of pending
// address beats, count of outstanding data beats). Two DUTs share stimulus:
// one with bursts enabled, one that splits bursts into single transfers.
module tb_ebu_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        IFUReq, IFUBurst, LSUReq, LSUBurst, LSUWrite, HREADY;
    logic [33:0] IFUAddr, LSUAddr;

    logic        IFUGrant, LSUGrant, IFUDone, LSUDone, HWRITE;
    logic [33:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;

    logic        nb_ifu_grant, nb_lsu_grant, nb_ifu_done, nb_lsu_done, nb_hwrite;
    logic [33:0] nb_haddr;
    logic [1:0]  nb_htrans;
    logic [2:0]  nb_hburst;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    int          m_owner;      // 0 none, 1 LSU, 2 IFU
    bit          m_skip;
    bit          m_burst, m_write;
    int          m_beats, m_data_left, m_outst;
    logic [33:0] m_addrq[$];
    logic [33:0] m_tail;

    // directed-run captures
    logic [33:0] cap_addr[$];
    logic [1:0]  cap_trans[$];
    logic [33:0] cap_nb_addr[$];
    logic [1:0]  cap_nb_trans[$];
    logic [2:0]  cap_nb_burst[$];
    logic        cap_nb_write[$];
    logic [33:0] cap_stall_addr[$];
    logic [1:0]  cap_stall_trans[$];
    int          done_order[$];
    int          done_cyc;

    always #5 HCLK = ~HCLK;

    ebu_arbiter #(.AHBW(64), .PA_BITS(34), .BURST_EN(1)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .IFUReq(IFUReq), .IFUBurst(IFUBurst), .IFUAddr(IFUAddr),
        .LSUReq(LSUReq), .LSUBurst(LSUBurst), .LSUWrite(LSUWrite), .LSUAddr(LSUAddr),
        .HREADY(HREADY),
        .IFUGrant(IFUGrant), .LSUGrant(LSUGrant), .IFUDone(IFUDone), .LSUDone(LSUDone),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HWRITE(HWRITE)
    );

    ebu_arbiter #(.AHBW(64), .PA_BITS(34), .BURST_EN(0)) u_dut_nb (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .IFUReq(IFUReq), .IFUBurst(IFUBurst), .IFUAddr(IFUAddr),
        .LSUReq(LSUReq), .LSUBurst(LSUBurst), .LSUWrite(LSUWrite), .LSUAddr(LSUAddr),
        .HREADY(HREADY),
        .IFUGrant(nb_ifu_grant), .LSUGrant(nb_lsu_grant), .IFUDone(nb_ifu_done), .LSUDone(nb_lsu_done),
        .HADDR(nb_haddr), .HTRANS(nb_htrans), .HBURST(nb_hburst), .HWRITE(nb_hwrite)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = 0; m_skip = 0; m_burst = 0; m_write = 0;
        m_beats = 0; m_data_left = 0; m_outst = 0; m_tail = '0;
        m_addrq.delete();
    endtask

    task automatic model_start(input int who, input logic [33:0] a, input bit b, input bit w);
        m_owner = who; m_burst = b; m_write = w;
        m_beats = b ? 4 : 1;
        m_data_left = m_beats; m_outst = 0;
        m_addrq.delete();
        for (int k = 0; k < m_beats; k++) m_addrq.push_back(a + 34'(k * 8));
        m_tail = a + 34'(m_beats * 8);
    endtask

    // one clock edge of the reference, using the inputs currently driven
    task automatic model_advance();
        if (!HRESETn) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (LSUReq && (!IFUReq || !m_skip)) begin
                if (IFUReq) m_skip = 1;
                model_start(1, LSUAddr, LSUBurst, LSUWrite);
            end else if (IFUReq) begin
                m_skip = 0;
                model_start(2, IFUAddr, IFUBurst, 1'b0);
            end
        end else if (HREADY) begin
            if (m_outst > 0) begin m_outst--; m_data_left--; end
            if (m_addrq.size() > 0) begin void'(m_addrq.pop_front()); m_outst++; end
            if (m_data_left == 0) m_owner = 0;
        end
    endtask

    task automatic check_model();
        logic [33:0] e_addr;
        logic [1:0]  e_tr, e_tr_nb;
        logic [2:0]  e_bu;
        logic        e_wr, e_ld, e_id;
        int          issued;
        e_addr = '0; e_tr = 2'b00; e_tr_nb = 2'b00; e_bu = 3'b000;
        e_wr = 0; e_ld = 0; e_id = 0;
        if (m_owner != 0) begin
            e_wr = m_write;
            e_bu = m_burst ? 3'b011 : 3'b000;
            if (m_addrq.size() > 0) begin
                issued  = m_beats - m_addrq.size();
                e_tr    = (issued == 0) ? 2'b10 : 2'b11;
                e_tr_nb = 2'b10;
                e_addr  = m_addrq[0];
            end else begin
                e_addr = m_tail;
            end
            if (HREADY && m_outst > 0 && m_data_left == 1) begin
                e_ld = (m_owner == 1);
                e_id = (m_owner == 2);
            end
        end
        chk("lsu_grant", LSUGrant, m_owner == 1);
        chk("ifu_grant", IFUGrant, m_owner == 2);
        chk("lsu_done",  LSUDone,  e_ld);
        chk("ifu_done",  IFUDone,  e_id);
        chk("htrans",    HTRANS,   e_tr);
        chk("haddr",     HADDR,    e_addr);
        chk("hburst",    HBURST,   e_bu);
        chk("hwrite",    HWRITE,   e_wr);
        chk("nb_ctl",    {nb_lsu_grant, nb_ifu_grant, nb_lsu_done, nb_ifu_done},
                         {m_owner == 1, m_owner == 2, e_ld, e_id});
        chk("nb_htrans", nb_htrans, e_tr_nb);
        chk("nb_haddr",  nb_haddr,  e_addr);
        chk("nb_hburst", nb_hburst, 3'b000);
        chk("nb_hwrite", nb_hwrite, e_wr);
    endtask

    task automatic settle();
        #1;
        check_model();
    endtask

    task automatic next();
        model_advance();
        @(negedge HCLK);
    endtask

    // run until target Done pulses and bus idle; optional HREADY stall window
    // given in 1-based cycles of bus ownership
    task automatic run(input int max_cyc, input bit auto_drop, input int stall_at,
                       input int stall_len, input int target);
        int  xfer, dones;
        bit  fin, ld, id;
        cap_addr.delete(); cap_trans.delete();
        cap_nb_addr.delete(); cap_nb_trans.delete(); cap_nb_burst.delete(); cap_nb_write.delete();
        cap_stall_addr.delete(); cap_stall_trans.delete(); done_order.delete();
        xfer = 0; dones = 0; fin = 0; done_cyc = -1;
        for (int c = 0; c < max_cyc && !fin; c++) begin
            HREADY = !(m_owner != 0 && (xfer + 1) >= stall_at && (xfer + 1) < stall_at + stall_len);
            settle();
            if (LSUGrant || IFUGrant) xfer++;
            if (HTRANS != 2'b00 && HREADY) begin cap_addr.push_back(HADDR); cap_trans.push_back(HTRANS); end
            if ((LSUGrant || IFUGrant) && !HREADY) begin
                cap_stall_addr.push_back(HADDR); cap_stall_trans.push_back(HTRANS);
            end
            if (nb_htrans != 2'b00 && HREADY) begin
                cap_nb_addr.push_back(nb_haddr); cap_nb_trans.push_back(nb_htrans);
                cap_nb_burst.push_back(nb_hburst); cap_nb_write.push_back(nb_hwrite);
            end
            ld = LSUDone; id = IFUDone;
            if (ld) begin done_order.push_back(1); done_cyc = xfer; dones++; end
            if (id) begin done_order.push_back(2); done_cyc = xfer; dones++; end
            next();
            if (auto_drop && ld) LSUReq = 0;
            if (auto_drop && id) IFUReq = 0;
            if (dones >= target && m_owner == 0) fin = 1;
        end
        chk("done_count", dones, target);
    endtask

    function automatic logic [33:0] rand_addr();
        logic [33:0] a;
        a = {2'($urandom_range(3)), 32'($urandom)};
        if ($urandom_range(7) == 0) a = 34'h3_FFFF_FFF0 | 34'($urandom_range(15));
        return a;
    endfunction

    task automatic apply_reset();
        HRESETn = 0;
        model_reset();
        settle();
        next();
        HRESETn = 1;
    endtask

    initial begin
        bit ld, id, rst_now;
        HRESETn = 0; HREADY = 1;
        IFUReq = 0; IFUBurst = 0; IFUAddr = '0;
        LSUReq = 0; LSUBurst = 0; LSUWrite = 0; LSUAddr = '0;
        model_reset();
        @(negedge HCLK);
        settle();
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 34'h0);
        next();
        HRESETn = 1;

        // LSU single read
        LSUReq = 1; LSUAddr = 34'h1000; LSUBurst = 0; LSUWrite = 0;
        run(20, 1, 0, 0, 1);
        chk("s1_nphases", cap_addr.size(), 1);
        chk("s1_addr", (cap_addr.size() > 0) ? cap_addr[0] : 'x, 34'h1000);
        chk("s1_trans", (cap_trans.size() > 0) ? cap_trans[0] : 'x, 2'b10);
        chk("s1_done_cyc", done_cyc, 2);

        // IFU burst
        IFUReq = 1; IFUAddr = 34'h2000; IFUBurst = 1;
        run(30, 1, 0, 0, 1);
        chk("s2_nphases", cap_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("s2_addr", (cap_addr.size() > k) ? cap_addr[k] : 'x, 34'h2000 + 34'(k * 8));
            chk("s2_trans", (cap_trans.size() > k) ? cap_trans[k] : 'x, (k == 0) ? 2'b10 : 2'b11);
        end
        chk("s2_done_cyc", done_cyc, 5);

        // IFU burst with HREADY low for 3 cycles on beat 2
        IFUReq = 1; IFUAddr = 34'h2000; IFUBurst = 1;
        run(30, 1, 3, 3, 1);
        chk("s4_done_cyc", done_cyc, 8);
        chk("s4_nstall", cap_stall_addr.size(), 3);
        for (int k = 0; k < 3; k++) begin
            chk("s4_stall_addr", (cap_stall_addr.size() > k) ? cap_stall_addr[k] : 'x, 34'h2010);
            chk("s4_stall_trans", (cap_stall_trans.size() > k) ? cap_stall_trans[k] : 'x, 2'b11);
        end

        // LSU burst write, split into singles on the BURST_EN=0 instance
        LSUReq = 1; LSUAddr = 34'h3000; LSUBurst = 1; LSUWrite = 1;
        run(30, 1, 0, 0, 1);
        chk("s5_nphases", cap_nb_addr.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("s5_addr", (cap_nb_addr.size() > k) ? cap_nb_addr[k] : 'x, 34'h3000 + 34'(k * 8));
            chk("s5_trans", (cap_nb_trans.size() > k) ? cap_nb_trans[k] : 'x, 2'b10);
            chk("s5_burst", (cap_nb_burst.size() > k) ? cap_nb_burst[k] : 'x, 3'b000);
            chk("s5_write", (cap_nb_write.size() > k) ? cap_nb_write[k] : 'x, 1'b1);
        end

        // both held from reset, singles: strict alternation starting with LSU
        apply_reset();
        LSUReq = 1; LSUAddr = 34'h100; LSUBurst = 0; LSUWrite = 0;
        IFUReq = 1; IFUAddr = 34'h200; IFUBurst = 0;
        run(40, 0, 0, 0, 4);
        chk("s3_ndone", done_order.size(), 4);
        for (int k = 0; k < 4; k++)
            chk("s3_order", (done_order.size() > k) ? done_order[k] : -1, (k % 2 == 0) ? 1 : 2);
        LSUReq = 0; IFUReq = 0;

        // reset during beat 1 of an IFU burst
        settle(); next();
        IFUReq = 1; IFUBurst = 1; IFUAddr = 34'h4000;
        settle(); next();
        settle(); next();
        LSUReq = 1; LSUAddr = 34'h5000; LSUBurst = 0; LSUWrite = 0;
        settle();
        chk("s6_beat1_addr", HADDR, 34'h4008);
        #1 HRESETn = 0;
        model_reset();
        #1;
        chk("s6_rst_htrans", HTRANS, 2'b00);
        chk("s6_rst_ignt", IFUGrant, 1'b0);
        check_model();
        next();
        HRESETn = 1;
        settle(); next();
        #1;
        chk("s6_lsu_first", LSUGrant, 1'b1);
        chk("s6_ifu_wait", IFUGrant, 1'b0);
        run(60, 1, 0, 0, 2);
        chk("s6_order0", (done_order.size() > 0) ? done_order[0] : -1, 1);
        chk("s6_order1", (done_order.size() > 1) ? done_order[1] : -1, 2);

        // randomized traffic
        LSUReq = 0; IFUReq = 0;
        for (int c = 0; c < 3000; c++) begin
            HREADY = ($urandom_range(9) < 8);
            if (!LSUReq && $urandom_range(3) == 0) begin
                LSUReq = 1; LSUBurst = 1'($urandom); LSUWrite = 1'($urandom); LSUAddr = rand_addr();
            end
            if (!IFUReq && $urandom_range(3) == 0) begin
                IFUReq = 1; IFUBurst = 1'($urandom); IFUAddr = rand_addr();
            end
            rst_now = ($urandom_range(499) == 0);
            settle();
            ld = LSUDone; id = IFUDone;
            if (rst_now) begin
                HRESETn = 0;
                model_reset();
                settle();
            end
            next();
            HRESETn = 1;
            if (ld) begin
                if ($urandom_range(1) == 0) LSUReq = 0;
                else begin LSUBurst = 1'($urandom); LSUWrite = 1'($urandom); LSUAddr = rand_addr(); end
            end
            if (id) begin
                if ($urandom_range(1) == 0) IFUReq = 0;
                else begin IFUBurst = 1'($urandom); IFUAddr = rand_addr(); end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
